id_loop_ctrl: RTL and testbench

- Decode stage that sits directly behind the fetch stage.
- Consumes fetch's id_instr/PC_out stream, decodes fields into a registered execute bundle, and owns hardware loop control.
- On a taken ENDL it drives Loop/PC_in back to fetch and squashes the single wrong-path instruction already in flight.
- Nested loops are tracked in a small hardware stack.

---
 rtl/id_pkg.sv | 27 ++
 rtl/id_loop_stack.sv | 49 ++++
 rtl/id_loop_ctrl.sv | 131 +++++++++++++
 tb/tb_id_loop_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared constants and payload types for the decode / hardware-loop stage.
package id_pkg;

    localparam int unsigned ID_PC_W  = 16;
    localparam int unsigned ID_CNT_W = 16;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_LOOP = 6'h3E;
    localparam logic [5:0] OP_ENDL = 6'h3F;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned RD_MSB  = 25;
    localparam int unsigned RD_LSB  = 21;
    localparam int unsigned RS_MSB  = 20;
    localparam int unsigned RS_LSB  = 16;
    localparam int unsigned RT_MSB  = 15;
    localparam int unsigned RT_LSB  = 11;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    typedef struct packed {
        logic [ID_PC_W-1:0]  start;
        logic [ID_CNT_W-1:0] remaining;
    } loop_entry_t;

endpackage

// File: rtl/id_loop_stack.sv
// LIFO of active hardware loops; top is read combinationally.
module id_loop_stack
    import id_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  loop_entry_t push_entry,
    input  logic        pop,
    input  logic        dec_top,
    output loop_entry_t top,
    output logic        full,
    output logic        empty
);

    localparam int unsigned SP_W  = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    loop_entry_t      entries [DEPTH];
    logic [SP_W-1:0]  sp;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] push_idx;

    assign top_idx  = IDX_W'(sp - SP_W'(1));
    assign push_idx = IDX_W'(sp);
    assign empty    = (sp == '0);
    assign full     = (sp == SP_W'(DEPTH));
    assign top      = empty ? '0 : entries[top_idx];

    // Operations are mutually exclusive by construction in the caller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (push && !full) begin
            entries[push_idx] <= push_entry;
            sp                <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end else if (dec_top && !empty) begin
            entries[top_idx].remaining <= entries[top_idx].remaining - ID_CNT_W'(1);
        end
    end

endmodule

// File: rtl/id_loop_ctrl.sv
// Decode stage with hardware loop control; redirects fetch on a taken ENDL.
// Optional build macro ID_LOOP_STATS_EN enables the loop_redirects counter.
module id_loop_ctrl
    import id_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = ID_PC_W,
    parameter int unsigned CNT_W = ID_CNT_W
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic [31:0]     id_instr,
    input  logic [PC_W-1:0] PC_out,
    output logic            Loop,
    output logic [PC_W-1:0] PC_in,
    output logic            ex_valid,
    output logic [5:0]      ex_opcode,
    output logic [4:0]      ex_rd,
    output logic [4:0]      ex_rs,
    output logic [4:0]      ex_rt,
    output logic [15:0]     ex_imm,
    output logic [PC_W-1:0] ex_pc,
    output logic            loop_err,
    output logic [15:0]     loop_redirects
);

    logic [PC_W-1:0] pc_d;
    logic            squash;
    logic [5:0]      opcode;
    logic            push;
    logic            pop;
    logic            dec_top;
    logic            fwd;
    logic            err_set;
    logic            full;
    logic            empty;
    loop_entry_t     top;
    loop_entry_t     push_entry;

    assign opcode                = id_instr[OPC_MSB:OPC_LSB];
    assign push_entry.start      = ID_PC_W'(pc_d + PC_W'(1));
    assign push_entry.remaining  = ID_CNT_W'(id_instr[IMM_MSB:IMM_LSB]);

    id_loop_stack #(
        .DEPTH (DEPTH)
    ) u_stack (
        .clk        (CLOCK_50),
        .rst_n      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .dec_top    (dec_top),
        .top        (top),
        .full       (full),
        .empty      (empty)
    );

    // Squashed slots make no decode or stack decision at all.
    always_comb begin
        push    = 1'b0;
        pop     = 1'b0;
        dec_top = 1'b0;
        fwd     = 1'b0;
        err_set = 1'b0;
        Loop    = 1'b0;
        PC_in   = '0;
        if (!squash) begin
            case (opcode)
                OP_LOOP: begin
                    fwd = 1'b1;
                    if (full) err_set = 1'b1;
                    else      push    = 1'b1;
                end
                OP_ENDL: begin
                    if (empty) begin
                        err_set = 1'b1;
                    end else if (top.remaining > ID_CNT_W'(1)) begin
                        Loop    = 1'b1;
                        PC_in   = PC_W'(top.start);
                        dec_top = 1'b1;
                    end else begin
                        pop = 1'b1;
                    end
                end
                default: fwd = (id_instr != 32'h0);
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            pc_d      <= '0;
            squash    <= 1'b0;
            loop_err  <= 1'b0;
            ex_valid  <= 1'b0;
            ex_opcode <= '0;
            ex_rd     <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_imm    <= '0;
            ex_pc     <= '0;
        end else begin
            pc_d     <= PC_out;
            squash   <= Loop;
            loop_err <= loop_err | err_set;
            ex_valid <= fwd;
            if (fwd) begin
                ex_opcode <= opcode;
                ex_rd     <= id_instr[RD_MSB:RD_LSB];
                ex_rs     <= id_instr[RS_MSB:RS_LSB];
                ex_rt     <= id_instr[RT_MSB:RT_LSB];
                ex_imm    <= id_instr[IMM_MSB:IMM_LSB];
                ex_pc     <= pc_d;
            end
        end
    end

`ifdef ID_LOOP_STATS_EN
    // Saturating count of taken redirects.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            loop_redirects <= '0;
        end else if (Loop && (loop_redirects != 16'hFFFF)) begin
            loop_redirects <= loop_redirects + 16'd1;
        end
    end
`else
    assign loop_redirects = '0;
`endif

endmodule

// File: tb/tb_id_loop_ctrl.sv
// Scoreboard bench for id_loop_ctrl with a behavioural fetch and loop-stack model.
module tb_id_loop_ctrl;

    localparam int DEPTH = 4;
`ifdef ID_LOOP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [31:0] id_instr;
    logic [15:0] PC_out;
    logic        Loop;
    logic [15:0] PC_in;
    logic        ex_valid;
    logic [5:0]  ex_opcode;
    logic [4:0]  ex_rd, ex_rs, ex_rt;
    logic [15:0] ex_imm;
    logic [15:0] ex_pc;
    logic        loop_err;
    logic [15:0] loop_redirects;

    always #5 CLOCK_50 = ~CLOCK_50;

    id_loop_ctrl dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .id_instr       (id_instr),
        .PC_out         (PC_out),
        .Loop           (Loop),
        .PC_in          (PC_in),
        .ex_valid       (ex_valid),
        .ex_opcode      (ex_opcode),
        .ex_rd          (ex_rd),
        .ex_rs          (ex_rs),
        .ex_rt          (ex_rt),
        .ex_imm         (ex_imm),
        .ex_pc          (ex_pc),
        .loop_err       (loop_err),
        .loop_redirects (loop_redirects)
    );

    typedef struct packed {
        logic        valid;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
        logic [15:0] pc;
    } bundle_t;

    int pass_cnt = 0;
    int total_cnt = 0;

    bundle_t     sb[$];
    logic [31:0] mem [256];

    int          m_sp;
    logic [15:0] m_start [DEPTH];
    logic [15:0] m_rem [DEPTH];
    bit          m_squash, m_err, m_redirect, f_valid;
    logic [15:0] m_target, m_pcd;
    int          m_redirects;

    bit          obs_loop, obs_ex_valid;
    logic [15:0] obs_ex_pc;

    function automatic logic [31:0] enc_loop(input logic [15:0] c);
        return {6'h3E, 10'h0, c};
    endfunction

    function automatic logic [31:0] enc_endl();
        return {6'h3F, 26'h0};
    endfunction

    function automatic logic [31:0] enc_alu(input logic [5:0] op, input logic [4:0] rd,
                                            input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 11'h15};
    endfunction

    function automatic void clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endfunction

    task automatic do_reset();
        reset    = 1'b0;
        id_instr = 32'h0;
        PC_out   = 16'h0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        m_sp = 0; m_squash = 0; m_err = 0; m_redirect = 0; m_redirects = 0;
        m_target = 0; m_pcd = 0; f_valid = 0;
        for (int i = 0; i < DEPTH; i++) begin m_start[i] = 0; m_rem[i] = 0; end
        sb.delete();
        reset = 1'b1;
    endtask

    // One decode cycle: score last cycle's bundle, drive fetch, model, check redirect.
    task automatic cycle();
        bundle_t     exp_b, act_b;
        logic [5:0]  op;
        bit          exp_loop;
        logic [15:0] exp_pcin;
        @(negedge CLOCK_50);
        obs_ex_valid = ex_valid;
        obs_ex_pc    = ex_pc;
        act_b = {ex_valid, ex_opcode, ex_rd, ex_rs, ex_rt, ex_imm, ex_pc};
        if (sb.size() != 0) begin
            exp_b = sb.pop_front();
            total_cnt++;
            if (exp_b.valid ? (act_b !== exp_b) : (ex_valid !== 1'b0))
                $display("FAIL ex_bundle t=%0t: got %h want %h", $time, act_b, exp_b);
            else pass_cnt++;
        end
        total_cnt++;
        if (loop_err !== m_err) $display("FAIL loop_err t=%0t: got %b want %b", $time, loop_err, m_err);
        else pass_cnt++;

        if (!f_valid) begin
            PC_out = 16'h0; id_instr = 32'h0; f_valid = 1;
        end else begin
            m_pcd    = PC_out;
            id_instr = mem[PC_out[7:0]];
            PC_out   = m_redirect ? m_target : PC_out + 16'd1;
        end

        exp_loop = 0; exp_pcin = 0; exp_b = '0;
        op = id_instr[31:26];
        if (!m_squash) begin
            if (op == 6'h3E) begin
                exp_b = {1'b1, op, id_instr[25:21], id_instr[20:16], id_instr[15:11], id_instr[15:0], m_pcd};
                if (m_sp == DEPTH) m_err = 1;
                else begin
                    m_start[m_sp] = m_pcd + 16'd1;
                    m_rem[m_sp]   = id_instr[15:0];
                    m_sp++;
                end
            end else if (op == 6'h3F) begin
                if (m_sp == 0) m_err = 1;
                else if (m_rem[m_sp-1] > 16'd1) begin
                    exp_loop = 1;
                    exp_pcin = m_start[m_sp-1];
                    m_rem[m_sp-1] = m_rem[m_sp-1] - 16'd1;
                end else m_sp--;
            end else if (id_instr != 32'h0) begin
                exp_b = {1'b1, op, id_instr[25:21], id_instr[20:16], id_instr[15:11], id_instr[15:0], m_pcd};
            end
        end
        m_squash = exp_loop; m_redirect = exp_loop; m_target = exp_pcin;
        if (exp_loop) m_redirects++;
        sb.push_back(exp_b);

        #1;
        obs_loop = Loop;
        total_cnt++;
        if ({Loop, PC_in} !== {exp_loop, exp_pcin})
            $display("FAIL redirect t=%0t: got Loop=%b PC_in=%h want Loop=%b PC_in=%h",
                     $time, Loop, PC_in, exp_loop, exp_pcin);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b0; id_instr = enc_endl(); PC_out = 16'h1234;
        #12;
        total_cnt++;
        if ({Loop, PC_in, ex_valid, loop_err} !== 19'h0)
            $display("FAIL reset_outs: got Loop=%b PC_in=%h ex_valid=%b loop_err=%b want all 0", Loop, PC_in, ex_valid, loop_err);
        else pass_cnt++;
        total_cnt++;
        if ({ex_opcode, ex_rd, ex_rs, ex_rt, ex_imm, ex_pc} !== 53'h0)
            $display("FAIL reset_fields: got %h want 0", {ex_opcode, ex_rd, ex_rs, ex_rt, ex_imm, ex_pc});
        else pass_cnt++;
        total_cnt++;
        if (loop_redirects !== 16'h0) $display("FAIL reset_redirects: got %0d want 0", loop_redirects);
        else pass_cnt++;
        total_cnt++;
        if (dut.u_stack.sp !== 0) $display("FAIL reset_sp: got %0d want 0", dut.u_stack.sp);
        else pass_cnt++;
        do_reset();
    endtask

    task automatic test_decode();
        int loops, valids;
        clear_mem();
        mem[0] = enc_alu(6'h01, 5'd3, 5'd4, 5'd5);
        mem[1] = enc_alu(6'h02, 5'd31, 5'd0, 5'd17);
        do_reset();
        loops = 0; valids = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (obs_loop) loops++;
            if (obs_ex_valid) valids++;
        end
        total_cnt++;
        if (loops != 0 || valids != 2) $display("FAIL decode_counts: got loops=%0d valids=%0d want 0 2", loops, valids);
        else pass_cnt++;
    endtask

    task automatic test_loop();
        int loops, body;
        clear_mem();
        mem[4] = enc_loop(16'd3);
        mem[5] = enc_alu(6'h01, 5'd1, 5'd2, 5'd3);
        mem[6] = enc_alu(6'h05, 5'd6, 5'd7, 5'd8);
        mem[7] = enc_endl();
        do_reset();
        loops = 0; body = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (obs_loop) loops++;
            if (obs_ex_valid && obs_ex_pc == 16'd5) body++;
        end
        total_cnt++;
        if (loops != 2 || body != 3) $display("FAIL loop3_counts: got loops=%0d body=%0d want 2 3", loops, body);
        else pass_cnt++;
        total_cnt++;
        if (dut.u_stack.sp !== 0) $display("FAIL loop3_sp: got %0d want 0", dut.u_stack.sp);
        else pass_cnt++;
    endtask

    task automatic test_nested();
        int loops, inner, outer;
        clear_mem();
        mem[0] = enc_loop(16'd2);
        mem[1] = enc_loop(16'd2);
        mem[2] = enc_alu(6'h01, 5'd9, 5'd9, 5'd1);
        mem[3] = enc_endl();
        mem[4] = enc_endl();
        do_reset();
        loops = 0; inner = 0; outer = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (obs_loop) loops++;
            if (obs_ex_valid && obs_ex_pc == 16'd2) inner++;
            if (obs_ex_valid && obs_ex_pc == 16'd1) outer++;
        end
        total_cnt++;
        if (loops != 3 || inner != 4 || outer != 2)
            $display("FAIL nested_counts: got loops=%0d inner=%0d outer=%0d want 3 4 2", loops, inner, outer);
        else pass_cnt++;
        total_cnt++;
        if (loop_err !== 1'b0 || dut.u_stack.sp !== 0)
            $display("FAIL nested_end: got err=%b sp=%0d want 0 0", loop_err, dut.u_stack.sp);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        int loops;
        clear_mem();
        for (int i = 0; i < DEPTH + 1; i++) mem[i] = enc_loop(16'd1);
        do_reset();
        for (int k = 0; k < 9; k++) cycle();
        total_cnt++;
        if (loop_err !== 1'b1 || dut.u_stack.sp !== DEPTH)
            $display("FAIL overflow: got err=%b sp=%0d want 1 %0d", loop_err, dut.u_stack.sp, DEPTH);
        else pass_cnt++;

        clear_mem();
        mem[0] = enc_endl();
        do_reset();
        loops = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (obs_loop) loops++;
        end
        total_cnt++;
        if (loop_err !== 1'b1 || loops != 0 || dut.u_stack.sp !== 0)
            $display("FAIL underflow: got err=%b loops=%0d sp=%0d want 1 0 0", loop_err, loops, dut.u_stack.sp);
        else pass_cnt++;
    endtask

    task automatic test_squash_hazard();
        int loops;
        // Wrong-path LOOP after a taken ENDL
        clear_mem();
        mem[0] = enc_loop(16'd2);
        mem[1] = enc_endl();
        mem[2] = enc_loop(16'd1);
        mem[3] = enc_endl();
        do_reset();
        loops = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (obs_loop) loops++;
            if (k == 4) begin
                total_cnt++;
                if (dut.u_stack.sp !== 1) $display("FAIL squash_loop_sp: got %0d want 1", dut.u_stack.sp);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (loops != 1 || loop_err !== 1'b0 || dut.u_stack.sp !== 0)
            $display("FAIL squash_loop_end: got loops=%0d err=%b sp=%0d want 1 0 0", loops, loop_err, dut.u_stack.sp);
        else pass_cnt++;

        // Wrong-path ENDL after a taken ENDL
        clear_mem();
        mem[0] = enc_loop(16'd1);
        mem[1] = enc_loop(16'd2);
        mem[2] = enc_endl();
        mem[3] = enc_endl();
        do_reset();
        loops = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (obs_loop) loops++;
            if (k == 5) begin
                total_cnt++;
                if (dut.u_stack.sp !== 2) $display("FAIL squash_endl_sp: got %0d want 2", dut.u_stack.sp);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (loops != 1 || loop_err !== 1'b0 || dut.u_stack.sp !== 0)
            $display("FAIL squash_endl_end: got loops=%0d err=%b sp=%0d want 1 0 0", loops, loop_err, dut.u_stack.sp);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_loop();
        int loops;
        clear_mem();
        mem[0] = enc_endl();
        mem[4] = enc_loop(16'd3);
        mem[5] = enc_alu(6'h01, 5'd1, 5'd2, 5'd3);
        mem[6] = enc_alu(6'h05, 5'd6, 5'd7, 5'd8);
        mem[7] = enc_endl();
        do_reset();
        loops = 0;
        for (int k = 0; k < 40 && loops < 2; k++) begin
            cycle();
            if (obs_loop) loops++;
        end
        total_cnt++;
        if (loops != 2) $display("FAIL midloop_reach: got loops=%0d want 2", loops);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({Loop, PC_in, ex_valid, loop_err} !== 19'h0 || dut.u_stack.sp !== 0 || loop_redirects !== 16'h0)
            $display("FAIL midloop_reset: got Loop=%b PC_in=%h ex_valid=%b err=%b sp=%0d redirects=%0d want all 0",
                     Loop, PC_in, ex_valid, loop_err, dut.u_stack.sp, loop_redirects);
        else pass_cnt++;

        mem[0] = 32'h0;
        do_reset();
        for (int k = 0; k < 30; k++) cycle();
        total_cnt++;
        if (loop_redirects !== (STATS ? 16'd2 : 16'd0))
            $display("FAIL redirect_count: got %0d want %0d", loop_redirects, STATS ? 2 : 0);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_loop();
        test_nested();
        test_overflow();
        test_squash_hazard();
        test_reset_mid_loop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timeout");
    end

endmodule
